// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO sizing: entry width, address width, depth and default
// almost-full / almost-empty levels, visible to the controller, the
// memory and the bench.
package fifo_ctrl_pkg;
   localparam int unsigned FIFO_DATA_W = 12;
   localparam int unsigned FIFO_ADDR_W = 3;
   localparam int unsigned FIFO_DEPTH  = 1 << FIFO_ADDR_W;
   localparam int unsigned FIFO_AF_LVL = 6;
   localparam int unsigned FIFO_AE_LVL = 2;
endpackage

// File: rtl/fifo_ctrl_if.sv
// User-side FIFO bus: push/pop requests, write data, read data and status.
//   master : the FIFO user (drives push, pop, data_in)
//   slave  : fifo_ctrl (drives data, valid, status and error flags)
interface fifo_ctrl_if
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned ADDR_W = FIFO_ADDR_W
);
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              err_ovf;
   logic              err_udf;

   modport master (
      output push, pop, data_in,
      input  data_out, valid_out, full, empty, almost_full, almost_empty,
             count, err_ovf, err_udf
   );

   modport slave (
      input  push, pop, data_in,
      output data_out, valid_out, full, empty, almost_full, almost_empty,
             count, err_ovf, err_udf
   );
endinterface

// File: rtl/fifo_ctrl_ptr.sv
// Write/read pointers and occupancy counter of the FIFO.
//   clk, reset         : clock, synchronous active-high reset
//   push_acc, pop_acc  : accepted push / pop this cycle
//   wr_ptr, rd_ptr     : memory write / read addresses (wrap modulo depth)
//   count              : occupancy, 0..depth
module fifo_ctrl_ptr
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_acc,
   input  logic              pop_acc,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] rd_ptr,
   output logic [ADDR_W:0]   count
);
   localparam int unsigned CNT_W = ADDR_W + 1;

   // Pointers wrap naturally; count moves only on an unmatched push or pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop_acc)  rd_ptr <= rd_ptr + ADDR_W'(1);
         if (push_acc && !pop_acc)
            count <= count + CNT_W'(1);
         else if (pop_acc && !push_acc)
            count <= count - CNT_W'(1);
      end
   end
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port memory (A = write,
// B = synchronous read, one-cycle latency).
//   clk, reset        : clock, synchronous active-high reset
//   bus               : user-side push/pop, data and status (slave modport)
//   we_a/addr_a/data_a: memory port A write strobe, address, data
//   we_b/addr_b/data_b: memory port B (read only, we_b/data_b tied 0)
//   q_b               : memory port B read data, becomes data_out
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned ADDR_W = FIFO_ADDR_W,
   parameter int unsigned AF_LVL = FIFO_AF_LVL,
   parameter int unsigned AE_LVL = FIFO_AE_LVL
) (
   input  logic              clk,
   input  logic              reset,
   fifo_ctrl_if.slave        bus,
   output logic              we_a,
   output logic [ADDR_W-1:0] addr_a,
   output logic [DATA_W-1:0] data_a,
   output logic              we_b,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] data_b,
   input  logic [DATA_W-1:0] q_b
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              full_c;
   logic              empty_c;
   logic              push_acc_c;
   logic              pop_acc_c;
   logic              valid_q;
   logic              err_ovf_q;
   logic              err_udf_q;

   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign empty_c = (count_q == '0);

   // No bypass: a pop on empty is dropped even with a push alongside.
   // A push on full is accepted only when a pop frees a slot this cycle.
   assign pop_acc_c  = !reset && bus.pop && !empty_c;
   assign push_acc_c = !reset && bus.push && (!full_c || pop_acc_c);

   fifo_ctrl_ptr #(.ADDR_W(ADDR_W)) u_ptr (
      .clk      (clk),
      .reset    (reset),
      .push_acc (push_acc_c),
      .pop_acc  (pop_acc_c),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr),
      .count    (count_q)
   );

   // Read-valid strobe and sticky drop flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         valid_q <= pop_acc_c;
         if (bus.push && !push_acc_c) err_ovf_q <= 1'b1;
         if (bus.pop  && !pop_acc_c)  err_udf_q <= 1'b1;
      end
   end

   assign we_a   = push_acc_c;
   assign addr_a = wr_ptr;
   assign data_a = bus.data_in;
   assign we_b   = 1'b0;
   assign addr_b = rd_ptr;
   assign data_b = '0;

   assign bus.data_out     = q_b;
   assign bus.valid_out    = valid_q;
   assign bus.full         = full_c;
   assign bus.empty        = empty_c;
   assign bus.almost_full  = (count_q >= CNT_W'(AF_LVL));
   assign bus.almost_empty = (count_q <= CNT_W'(AE_LVL));
   assign bus.count        = count_q;
   assign bus.err_ovf      = err_ovf_q;
   assign bus.err_udf      = err_udf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with an external behavioural dual-port memory:
// a directed vector table, then random traffic against a queue model.
module tb_fifo_ctrl;
   import fifo_ctrl_pkg::*;

   localparam int unsigned DW = FIFO_DATA_W;
   localparam int unsigned AW = FIFO_ADDR_W;

   logic          clk = 1'b0;
   logic          reset;
   logic          we_a, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] data_a, data_b, q_b;
   logic [DW-1:0] mem [FIFO_DEPTH];

   fifo_ctrl_if bus ();

   fifo_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .we_a   (we_a),
      .addr_a (addr_a),
      .data_a (data_a),
      .we_b   (we_b),
      .addr_b (addr_b),
      .data_b (data_b),
      .q_b    (q_b)
   );

   always #5 clk = ~clk;

   // External memory: port A write, port B synchronous read.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= data_a;
      q_b <= mem[addr_b];
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic drive(input logic r, input logic p, input logic po, input logic [DW-1:0] d);
      reset    = r;
      bus.push = p;
      bus.pop  = po;
      bus.data_in = d;
   endtask

   // Directed vectors: inputs, in-cycle port A expectations, post-edge state.
   typedef struct {
      logic          rst, push, pop;
      logic [DW-1:0] din;
      logic          we;
      logic [AW-1:0] addr;
      logic [AW:0]   cnt;
      logic          full, empty, af, ae, ovf, udf, vld;
      logic [DW-1:0] dout;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic rst, push, pop, input logic [DW-1:0] din,
                              input logic we, input logic [AW-1:0] a, input logic [AW:0] c,
                              input logic f, e, af, ae, ov, ud, vl, input logic [DW-1:0] d);
      vec_t r;
      r.rst = rst; r.push = push; r.pop = pop; r.din = din;
      r.we = we; r.addr = a; r.cnt = c;
      r.full = f; r.empty = e; r.af = af; r.ae = ae;
      r.ovf = ov; r.udf = ud; r.vld = vl; r.dout = d;
      return r;
   endfunction

   // Reference model: queue of stored entries plus push/pop totals.
   logic [DW-1:0] mq[$];
   int unsigned   wcnt, rcnt;
   logic          movf, mudf, mvld;
   logic [DW-1:0] mdata;

   task automatic model_step(input logic r, input logic p, input logic po, input logic [DW-1:0] d);
      logic pa, ph;
      if (r) begin
         mq.delete();
         wcnt = 0; rcnt = 0;
         movf = 1'b0; mudf = 1'b0; mvld = 1'b0;
      end else begin
         pa = po && (mq.size() != 0);
         ph = p && ((mq.size() < FIFO_DEPTH) || pa);
         mvld = pa;
         if (pa) begin
            mdata = mq.pop_front();
            rcnt++;
         end
         if (ph) begin
            mq.push_back(d);
            wcnt++;
         end
         if (p && !ph)  movf = 1'b1;
         if (po && !pa) mudf = 1'b1;
      end
   endtask

   task automatic model_check(input logic r, input logic p, input logic po, input logic [DW-1:0] d);
      logic ew;
      int   sz;
      sz = mq.size();
      ew = !r && p && ((sz < FIFO_DEPTH) || (po && sz != 0));
      chk("r_count",  32'(bus.count), 32'(sz));
      chk("r_full",   32'(bus.full), 32'(sz == FIFO_DEPTH));
      chk("r_empty",  32'(bus.empty), 32'(sz == 0));
      chk("r_afull",  32'(bus.almost_full), 32'(sz >= FIFO_AF_LVL));
      chk("r_aempty", 32'(bus.almost_empty), 32'(sz <= FIFO_AE_LVL));
      chk("r_ovf",    32'(bus.err_ovf), 32'(movf));
      chk("r_udf",    32'(bus.err_udf), 32'(mudf));
      chk("r_valid",  32'(bus.valid_out), 32'(mvld));
      if (mvld) chk("r_dout", 32'(bus.data_out), 32'(mdata));
      chk("r_addr_b", 32'(addr_b), rcnt % FIFO_DEPTH);
      chk("r_we_a",   32'(we_a), 32'(ew));
      chk("r_addr_a", 32'(addr_a), wcnt % FIFO_DEPTH);
      if (ew) chk("r_data_a", 32'(data_a), 32'(d));
      chk("r_we_b",   32'(we_b), 32'(0));
      chk("r_data_b", 32'(data_b), 32'(0));
   endtask

   initial begin
      // Reset, push A/B/AA, pop x3
      tbl.push_back(v(1,0,0,12'h000, 0,0, 0,0,1,0,1,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h00A, 1,0, 1,0,0,0,1,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h00B, 1,1, 2,0,0,0,1,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h0AA, 1,2, 3,0,0,0,0,0,0,0,12'h000));
      tbl.push_back(v(0,0,1,12'h000, 0,3, 2,0,0,0,1,0,0,1,12'h00A));
      tbl.push_back(v(0,0,1,12'h000, 0,3, 1,0,0,0,1,0,0,1,12'h00B));
      tbl.push_back(v(0,0,1,12'h000, 0,3, 0,0,1,0,1,0,0,1,12'h0AA));
      tbl.push_back(v(0,0,0,12'h000, 0,3, 0,0,1,0,1,0,0,0,12'h000));
      // Fill 8 entries starting at address 3
      tbl.push_back(v(0,1,0,12'h100, 1,3, 1,0,0,0,1,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h101, 1,4, 2,0,0,0,1,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h102, 1,5, 3,0,0,0,0,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h103, 1,6, 4,0,0,0,0,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h104, 1,7, 5,0,0,0,0,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h105, 1,0, 6,0,0,1,0,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h106, 1,1, 7,0,0,1,0,0,0,0,12'h000));
      tbl.push_back(v(0,1,0,12'h107, 1,2, 8,1,0,1,0,0,0,0,12'h000));
      // Full with push+pop: oldest out, no overflow, pointers reach 0
      tbl.push_back(v(0,1,1,12'h1A0, 1,3, 8,1,0,1,0,0,0,1,12'h100));
      tbl.push_back(v(0,1,1,12'h1A1, 1,4, 8,1,0,1,0,0,0,1,12'h101));
      tbl.push_back(v(0,1,1,12'h1A2, 1,5, 8,1,0,1,0,0,0,1,12'h102));
      tbl.push_back(v(0,1,1,12'h1A3, 1,6, 8,1,0,1,0,0,0,1,12'h103));
      tbl.push_back(v(0,1,1,12'h1A4, 1,7, 8,1,0,1,0,0,0,1,12'h104));
      // 9th push dropped
      tbl.push_back(v(0,1,0,12'h1FF, 0,0, 8,1,0,1,0,1,0,0,12'h000));
      // Pop down to 5 after the wrap
      tbl.push_back(v(0,0,1,12'h000, 0,0, 7,0,0,1,0,1,0,1,12'h105));
      tbl.push_back(v(0,0,1,12'h000, 0,0, 6,0,0,1,0,1,0,1,12'h106));
      tbl.push_back(v(0,0,1,12'h000, 0,0, 5,0,0,0,0,1,0,1,12'h107));
      // Reset at count 5, requests ignored
      tbl.push_back(v(1,1,1,12'h555, 0,0, 0,0,1,0,1,0,0,0,12'h000));
      // Empty with push+pop: push only, underflow
      tbl.push_back(v(0,1,1,12'h3C3, 1,0, 1,0,0,0,1,0,1,0,12'h000));
      tbl.push_back(v(0,0,1,12'h000, 0,1, 0,0,1,0,1,0,1,1,12'h3C3));
      tbl.push_back(v(0,0,1,12'h000, 0,1, 0,0,1,0,1,0,1,0,12'h000));

      drive(1, 0, 0, '0);
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].din);
         #1;
         chk($sformatf("v%0d_we_a", i),   32'(we_a), 32'(tbl[i].we));
         chk($sformatf("v%0d_addr_a", i), 32'(addr_a), 32'(tbl[i].addr));
         if (tbl[i].we) chk($sformatf("v%0d_data_a", i), 32'(data_a), 32'(tbl[i].din));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_count", i),  32'(bus.count), 32'(tbl[i].cnt));
         chk($sformatf("v%0d_full", i),   32'(bus.full), 32'(tbl[i].full));
         chk($sformatf("v%0d_empty", i),  32'(bus.empty), 32'(tbl[i].empty));
         chk($sformatf("v%0d_afull", i),  32'(bus.almost_full), 32'(tbl[i].af));
         chk($sformatf("v%0d_aempty", i), 32'(bus.almost_empty), 32'(tbl[i].ae));
         chk($sformatf("v%0d_ovf", i),    32'(bus.err_ovf), 32'(tbl[i].ovf));
         chk($sformatf("v%0d_udf", i),    32'(bus.err_udf), 32'(tbl[i].udf));
         chk($sformatf("v%0d_valid", i),  32'(bus.valid_out), 32'(tbl[i].vld));
         if (tbl[i].vld) chk($sformatf("v%0d_dout", i), 32'(bus.data_out), 32'(tbl[i].dout));
      end

      // Random traffic with phases biased toward filling or draining.
      drive(1, 0, 0, '0);
      @(posedge clk);
      model_step(1, 0, 0, '0);
      #1;
      for (int ph = 0; ph < 12; ph++) begin
         int unsigned push_pct;
         int unsigned pop_pct;
         push_pct = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
         pop_pct  = 100 - push_pct;
         for (int c = 0; c < 120; c++) begin
            logic          r, p, po;
            logic [DW-1:0] d;
            r  = ($urandom_range(99) == 0);
            p  = ($urandom_range(99) < push_pct);
            po = ($urandom_range(99) < pop_pct);
            d  = DW'($urandom);
            drive(r, p, po, d);
            #1;
            model_check(r, p, po, d);
            @(posedge clk);
            model_step(r, p, po, d);
            #1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 12, entry width; ADDR_W, default 3, memory address width (depth 2**ADDR_W = 8); AF_LVL, default 6, almost-full level; AE_LVL, default 2, almost-empty level.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write request.
- pop  in  1  read request.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data; equals q_b.
- valid_out  out  1  data_out holds popped entry.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LVL.
- almost_empty  out  1  count <= AE_LVL.
- count  out  ADDR_W+1  current occupancy, 0..8.
- err_ovf  out  1  sticky; a push was dropped.
- err_udf  out  1  sticky; a pop was dropped.
- we_a  out  1  memory port A write enable.
- addr_a  out  ADDR_W  memory port A address (write pointer).
- data_a  out  DATA_W  memory port A write data.
- we_b  out  1  memory port B write enable; tied 0.
- addr_b  out  ADDR_W  memory port B address (read pointer).
- data_b  out  DATA_W  memory port B write data; tied 0.
- q_b  in  DATA_W  memory port B read data; synchronous read, valid one clk after addr_b.

Function
REQ-003 Push SHALL be accepted when push=1 and (full=0 or an accepted pop occurs in the same cycle); pop SHALL be accepted when pop=1 and empty=0.
REQ-004 On an accepted push, during that cycle: we_a=1, addr_a=wr_ptr, data_a=data_in (combinational). At the clock edge wr_ptr SHALL increment modulo 8. Otherwise we_a=0.
REQ-005 addr_b SHALL equal rd_ptr at all times; an accepted pop SHALL increment rd_ptr modulo 8 at the clock edge.
REQ-006 valid_out SHALL be a register set to 1 the cycle after an accepted pop, else 0; read latency is 1 cycle. data_out SHALL be q_b.
REQ-007 count SHALL be +1 on push only, -1 on pop only, and unchanged on push+pop or when neither request is accepted.
REQ-008 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered count.
REQ-009 When full and push+pop occur together, both SHALL be accepted, count stays 8, and err_ovf SHALL NOT set.
REQ-010 When empty and push+pop occur together, only the push SHALL be accepted (no bypass), count becomes 1, and err_udf SHALL set.
REQ-011 If push is dropped, err_ovf SHALL set at the next edge. If pop is dropped, err_udf SHALL set at the next edge. Both flags hold until reset.
REQ-012 Pointer wrap from 7 to 0 SHALL NOT affect count or flags.

Reset
REQ-013 At a clk edge with reset=1, wr_ptr, rd_ptr, count, valid_out, err_ovf and err_udf SHALL become 0. Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-014 During reset, we_a SHALL be 0 and push/pop SHALL be ignored.
REQ-015 Reset asserted mid-operation SHALL discard all stored entries logically; memory contents are not cleared.

Structure
REQ-016 DATA_W, ADDR_W, depth and the AF/AE defaults SHALL live in a shared package, so they are also visible to the memory and the probador.
REQ-017 No sub-module is required. The pointer/count logic MAY be factored as fifo_ptr. The dual-port memory SHALL be instantiated externally, alongside fifo_ctrl in the testbench top.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, then push 0x00A,0x00B,0x0AA -> count=3, addr_a steps 0,1,2, empty=0.
- Pop ×3 after the previous scenario -> valid_out pulses one cycle after each pop, data_out=0x00A,0x00B,0x0AA in order, empty=1.
- Push 8 entries -> full=1, almost_full from count 6. A 9th push -> err_ovf=1, count=8.
- Full with push+pop same cycle -> count stays 8, err_ovf stays 0, the oldest entry is output, wr_ptr and rd_ptr wrap to 0.
- Empty with push+pop -> count=1, err_udf=1, valid_out=0 next cycle.
- Reset asserted with count=5 -> next cycle count=0, empty=1, err flags 0, valid_out=0.
